// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular add/sub pipeline: op encoding and default width/modulus.
package mod_arith_pkg;
  localparam int DEF_W = 4;
  localparam int DEF_M = 15;

  localparam int OP_SUB_BIT = 0;
  localparam int OP_ACC_BIT = 1;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;
endpackage

// File: rtl/mod_addsub_pipe_reduce.sv
// Combinational mod-M correction of a signed raw sum/difference lying in (-M, 2M).
module mod_reduce #(
  parameter int W = 4,
  parameter int M = 15
) (
  input  logic signed [W+1:0] raw_i,
  output logic        [W-1:0] z_o
);
  localparam logic signed [W+1:0] MS = (W+2)'(M);

  logic signed [W+1:0] red;
  logic        [1:0]   unused_hi;

  always_comb begin
    red = raw_i;
    if (raw_i >= MS)     red = raw_i - MS;
    else if (raw_i < 0)  red = raw_i + MS;
  end

  assign z_o       = red[W-1:0];
  assign unused_hi = red[W+1:W];
endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/sub pipeline with valid/ready handshakes on both sides.
// Define MOD_ADDSUB_ACC_EN to build in the accumulator, acc ops and acc_clr.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int M = DEF_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         err
);
  localparam logic [W-1:0] MW = W'(M);

  logic                s1_valid_q, s1_err_q;
  logic signed [W+1:0] s1_raw_q, raw_d;
  logic                s2_valid_q, s2_err_q;
  logic        [W-1:0] s2_z_q, red_z, opa, opb;
  logic                s2_free, s1_adv, accept, op_err, is_sub;

  assign s2_free = !s2_valid_q || out_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign accept  = in_valid && in_ready;
  assign is_sub  = op[OP_SUB_BIT];

`ifdef MOD_ADDSUB_ACC_EN
  logic         s1_acc_q, is_acc;
  logic [W-1:0] acc_q;

  assign is_acc = op[OP_ACC_BIT];
  assign opa    = is_acc ? acc_q : x;
  assign opb    = is_acc ? x : y;
  assign op_err = is_acc ? (x >= MW) : (x >= MW || y >= MW);
  // Acc ops read acc at acceptance, so a second one waits until the first has written back.
  assign in_ready = (!s1_valid_q || s1_adv) && !acc_clr &&
                    !(is_acc && s1_valid_q && s1_acc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_acc_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      if (!s1_valid_q || s1_adv) s1_acc_q <= accept && is_acc;
      if (acc_clr)
        acc_q <= '0;
      else if (s1_adv && s1_acc_q && !s1_err_q)
        acc_q <= red_z;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{acc_clr, op[OP_ACC_BIT]};
  assign opa        = x;
  assign opb        = y;
  assign op_err     = (x >= MW) || (y >= MW);
  assign in_ready   = !s1_valid_q || s1_adv;
`endif

  assign raw_d = op_err ? '0 :
                 is_sub ? $signed({2'b00, opa}) - $signed({2'b00, opb})
                        : $signed({2'b00, opa}) + $signed({2'b00, opb});

  mod_reduce #(.W(W), .M(M)) u_reduce (
    .raw_i (s1_raw_q),
    .z_o   (red_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_raw_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_z_q     <= '0;
    end else begin
      if (!s1_valid_q || s1_adv) begin
        s1_valid_q <= accept;
        s1_err_q   <= op_err;
        s1_raw_q   <= raw_d;
      end
      if (s2_free) begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        s2_z_q     <= s1_err_q ? '0 : red_z;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign z         = s2_z_q;
  assign err       = s2_err_q;
endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter W, default 4: operand and result width in bits.
REQ-003 Parameter M, default 15 (4'b1111): modulus, legal range 2 <= M <= 2^W-1.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready
- op  in  2  00 add, 01 sub, 10 acc_add, 11 acc_sub
- x  in  W  first operand
- y  in  W  second operand, ignored for acc ops
- acc_clr  in  1  synchronous accumulator clear pulse
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready
- z  out  W  result, always in [0, M-1]
- err  out  1  range error for this result

Function
REQ-005 add SHALL produce (x+y) mod M; sub SHALL produce (x-y) mod M as a non-negative value.
REQ-006 acc_add SHALL produce acc' = (acc+x) mod M; acc_sub SHALL produce acc' = (acc-x) mod M; z = acc'.
REQ-007 Stage 1 SHALL register a signed W+2-bit raw sum/difference; stage 2 SHALL reduce it (subtract M if raw >= M, add M if raw < 0) and register z/err.
REQ-008 Latency SHALL be 2 cycles from acceptance to out_valid; with out_ready held high, throughput SHALL be one result per cycle.
REQ-009 Backpressure: a stage SHALL hold its contents while the downstream stage is occupied and not advancing; in_ready = !s1_valid | s1_advance.
REQ-010 out_valid, z and err SHALL stay stable while out_valid & !out_ready.
REQ-011 Any operand used (x; y for non-acc ops) >= M SHALL yield err=1, z=0, and no accumulator update.
REQ-012 acc SHALL be updated when the acc op moves from stage 1 to stage 2.
REQ-013 An acc op SHALL NOT be accepted while another acc op occupies stage 1 (in_ready forced low).
REQ-014 acc_clr SHALL set acc to 0 on the next edge, take priority over a same-cycle acc update, and hold in_ready low in that cycle; the in-flight result is still delivered unchanged.
REQ-015 Results SHALL leave in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-016 On rst_n low: out_valid=0, z=0, err=0, acc=0, and both stage valids=0, immediately and independent of clk.
REQ-017 A reset asserted mid-operation SHALL discard all in-flight requests; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-018 With MOD_ADDSUB_ACC_EN defined, the accumulator, acc ops, acc_clr and REQ-013/014 SHALL be present.
REQ-019 Without MOD_ADDSUB_ACC_EN, op[1] SHALL be ignored (10 behaves as add, 11 as sub), acc_clr SHALL be ignored, and no accumulator register SHALL exist.

Structure
REQ-020 Package mod_arith_pkg SHALL hold the op encoding constants and the default W/M values.
REQ-021 The stage-2 reduction SHALL be a combinational sub-module mod_reduce (raw in, z out).

Verification (W=4, M=15)
REQ-022 add x=7, y=9 -> z=1, err=0, out_valid 2 cycles after acceptance; sub x=3, y=5 -> z=13.
REQ-023 Exhaustive sweep of op in {00,01}, x,y in 0..14 with out_ready=1 -> 450 results, all matching the mod-M model, one per cycle.
REQ-024 acc_clr, then acc_add 9, acc_add 9, acc_sub 4 -> z=9, 3, 14; the second acc op is stalled one cycle by in_ready.
REQ-025 x=15, y=0, add -> err=1, z=0; a following acc_add 2 with acc=14 -> z=1 (accumulator unaffected by the error).
REQ-026 out_ready low for 5 cycles with 3 requests sent -> in_ready low once both stages are full, z stable, and all 3 results delivered in order after release.
REQ-027 rst_n pulsed low with 2 requests in flight -> out_valid=0 at once, no stale result afterwards, acc=0.
